// File: rtl/cpu_io_control_if.sv
// External memory bus between cpu_io_control (master) and the memory system (slave).
// One outstanding request; mem_req is held until mem_ack.
interface cpu_io_control_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/cpu_io_control.sv
// Bus handshake engine for the CPU: one fetch/load/store transaction per *_io cpu_state.
// Optional ack timeout is enabled by defining CPU_IO_TIMEOUT_EN.
`ifndef CPU_FETCH_BEGIN
`define CPU_FETCH_BEGIN   4'h0
`endif
`ifndef CPU_FETCH_IO
`define CPU_FETCH_IO      4'h1
`endif
`ifndef CPU_FETCH_END
`define CPU_FETCH_END     4'h2
`endif
`ifndef CPU_DECODE
`define CPU_DECODE        4'h3
`endif
`ifndef CPU_EXEC_BEGIN
`define CPU_EXEC_BEGIN    4'h4
`endif
`ifndef CPU_EXEC_LOAD_IO
`define CPU_EXEC_LOAD_IO  4'h5
`endif
`ifndef CPU_EXEC_STORE_IO
`define CPU_EXEC_STORE_IO 4'h6
`endif
`ifndef CPU_EXEC_END
`define CPU_EXEC_END      4'h7
`endif

module cpu_io_control #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cpu_state,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              io_err,
  cpu_io_control_if.master  mem
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic is_fetch, is_load, is_store, is_io;

  assign is_fetch = (cpu_state == `CPU_FETCH_IO);
  assign is_load  = (cpu_state == `CPU_EXEC_LOAD_IO);
  assign is_store = (cpu_state == `CPU_EXEC_STORE_IO);
  assign is_io    = is_fetch | is_load | is_store;

`ifdef CPU_IO_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_hit;

  // Counter holds the number of ack-less BUSY cycles already elapsed.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
`ifdef CPU_IO_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (is_io) begin
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = is_fetch ? pc_addr : data_addr;
          wdata_d = wdata;
          state_d = BUSY;
`ifdef CPU_IO_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        if (!is_io) begin
          // cpu_control abandoned the transaction: drop the bus quietly.
          req_d   = 1'b0;
          state_d = IDLE;
        end else if (mem.mem_ack) begin
          req_d   = 1'b0;
          ready_d = 1'b1;
          if (!we_q) begin
            rdata_d = mem.mem_rdata;
          end
          state_d = DONE;
        end
`ifdef CPU_IO_TIMEOUT_EN
        else if (timeout_hit) begin
          req_d   = 1'b0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          if (!we_q) begin
            rdata_d = '1;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        // Wait for cpu_control to leave the io state so the request is not reissued.
        if (!is_io) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef CPU_IO_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign ready         = ready_q;
  assign rdata         = rdata_q;
  assign io_err        = err_q;

endmodule

// File: tb/tb_cpu_io_control.sv
// Directed bench for cpu_io_control: fetch, store, back-to-back, abort, async reset,
// and the ack timeout when CPU_IO_TIMEOUT_EN is defined.
`ifndef CPU_FETCH_BEGIN
`define CPU_FETCH_BEGIN   4'h0
`endif
`ifndef CPU_FETCH_IO
`define CPU_FETCH_IO      4'h1
`endif
`ifndef CPU_FETCH_END
`define CPU_FETCH_END     4'h2
`endif
`ifndef CPU_DECODE
`define CPU_DECODE        4'h3
`endif
`ifndef CPU_EXEC_BEGIN
`define CPU_EXEC_BEGIN    4'h4
`endif
`ifndef CPU_EXEC_LOAD_IO
`define CPU_EXEC_LOAD_IO  4'h5
`endif
`ifndef CPU_EXEC_STORE_IO
`define CPU_EXEC_STORE_IO 4'h6
`endif
`ifndef CPU_EXEC_END
`define CPU_EXEC_END      4'h7
`endif

module tb_cpu_io_control;
`ifdef CPU_IO_TIMEOUT_EN
  localparam int unsigned TMO = 4;
`else
  localparam int unsigned TMO = 255;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  cpu_state;
  logic [15:0] pc_addr;
  logic [15:0] data_addr;
  logic [15:0] wdata;
  logic        ready;
  logic [15:0] rdata;
  logic        io_err;

  int tests;
  int fails;

  cpu_io_control_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  cpu_io_control #(
    .ADDR_W        (16),
    .DATA_W        (16),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_state(cpu_state),
    .pc_addr  (pc_addr),
    .data_addr(data_addr),
    .wdata    (wdata),
    .ready    (ready),
    .rdata    (rdata),
    .io_err   (io_err),
    .mem      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", bus.mem_req); end
    tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", bus.mem_we); end
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", ready); end
    tests++; if (io_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", io_err); end
    tests++; if (bus.mem_addr !== 16'h0000) begin fails++; $display("FAIL reset_addr: got %h want 0000", bus.mem_addr); end
    tests++; if (bus.mem_wdata !== 16'h0000) begin fails++; $display("FAIL reset_wdata: got %h want 0000", bus.mem_wdata); end
    tests++; if (rdata !== 16'h0000) begin fails++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    cpu_state     = `CPU_FETCH_IO;
    pc_addr       = 16'h0040;
    data_addr     = 16'h0999;
    bus.mem_rdata = 16'hA5C3;
    bus.mem_ack   = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) bus.mem_ack = 1'b1;
      tests++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL fetch_req_c%0d: got %b want 1", c, bus.mem_req); end
      tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL fetch_we_c%0d: got %b want 0", c, bus.mem_we); end
      tests++; if (bus.mem_addr !== 16'h0040) begin fails++; $display("FAIL fetch_addr_c%0d: got %h want 0040", c, bus.mem_addr); end
      tests++; if (ready !== 1'b0) begin fails++; $display("FAIL fetch_early_ready_c%0d: got %b want 0", c, ready); end
    end
    tick();
    bus.mem_ack = 1'b0;
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL fetch_ready: got %b want 1", ready); end
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL fetch_req_drop: got %b want 0", bus.mem_req); end
    tests++; if (rdata !== 16'hA5C3) begin fails++; $display("FAIL fetch_rdata: got %h want a5c3", rdata); end
    tests++; if (io_err !== 1'b0) begin fails++; $display("FAIL fetch_err: got %b want 0", io_err); end
    tick();
    cpu_state = `CPU_FETCH_END;
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL fetch_ready_pulse: got %b want 0", ready); end
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL fetch_no_reissue: got %b want 0", bus.mem_req); end
    tick();
  endtask

  task automatic test_store();
    cpu_state     = `CPU_EXEC_STORE_IO;
    data_addr     = 16'h0100;
    wdata         = 16'hBEEF;
    bus.mem_rdata = 16'h7777;
    bus.mem_ack   = 1'b1;
    tick();
    tests++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL store_req: got %b want 1", bus.mem_req); end
    tests++; if (bus.mem_we !== 1'b1) begin fails++; $display("FAIL store_we: got %b want 1", bus.mem_we); end
    tests++; if (bus.mem_addr !== 16'h0100) begin fails++; $display("FAIL store_addr: got %h want 0100", bus.mem_addr); end
    tests++; if (bus.mem_wdata !== 16'hBEEF) begin fails++; $display("FAIL store_wdata: got %h want beef", bus.mem_wdata); end
    tick();
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL store_ready: got %b want 1", ready); end
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL store_req_1cyc: got %b want 0", bus.mem_req); end
    // cpu_state lingers in store_io with ack still high: no second request allowed.
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL store_reissue_c%0d: got %b want 0", c, bus.mem_req); end
      tests++; if (ready !== 1'b0) begin fails++; $display("FAIL store_ready_extra_c%0d: got %b want 0", c, ready); end
    end
    tests++; if (rdata !== 16'hA5C3) begin fails++; $display("FAIL store_rdata_kept: got %h want a5c3", rdata); end
    cpu_state   = `CPU_EXEC_END;
    bus.mem_ack = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    cpu_state     = `CPU_FETCH_IO;
    pc_addr       = 16'h0040;
    bus.mem_rdata = 16'h1111;
    bus.mem_ack   = 1'b1;
    tick();
    tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0040) begin fails++; $display("FAIL b2b_first_req: got req=%b addr=%h want req=1 addr=0040", bus.mem_req, bus.mem_addr); end
    tick();
    tests++; if (ready !== 1'b1 || rdata !== 16'h1111) begin fails++; $display("FAIL b2b_first_done: got ready=%b rdata=%h want ready=1 rdata=1111", ready, rdata); end
    tick();
    cpu_state = `CPU_FETCH_END;
    tick();
    cpu_state     = `CPU_EXEC_LOAD_IO;
    data_addr     = 16'h0200;
    bus.mem_rdata = 16'h1234;
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL b2b_gap: got %b want 0", bus.mem_req); end
    tick();
    tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0200) begin fails++; $display("FAIL b2b_second_req: got req=%b addr=%h want req=1 addr=0200", bus.mem_req, bus.mem_addr); end
    tick();
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL b2b_second_ready: got %b want 1", ready); end
    tests++; if (rdata !== 16'h1234) begin fails++; $display("FAIL b2b_rdata: got %h want 1234", rdata); end
    tick();
    cpu_state   = `CPU_EXEC_END;
    bus.mem_ack = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_abort();
    cpu_state   = `CPU_FETCH_IO;
    pc_addr     = 16'h0300;
    bus.mem_ack = 1'b0;
    tick();
    tests++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL abort_req: got %b want 1", bus.mem_req); end
    tick();
    cpu_state = `CPU_FETCH_BEGIN;
    tick();
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL abort_drop: got %b want 0", bus.mem_req); end
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL abort_ready: got %b want 0", ready); end
    // Late ack while idle must be ignored.
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    tick();
    tests++; if (ready !== 1'b0 || bus.mem_req !== 1'b0) begin fails++; $display("FAIL abort_stray_ack: got ready=%b req=%b want 0 0", ready, bus.mem_req); end
    tests++; if (rdata !== 16'h1234) begin fails++; $display("FAIL abort_rdata_kept: got %h want 1234", rdata); end
    bus.mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    cpu_state   = `CPU_FETCH_IO;
    pc_addr     = 16'h0040;
    bus.mem_ack = 1'b0;
    tick();
    tests++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL areset_pre_req: got %b want 1", bus.mem_req); end
    #2;
    reset = 1'b0;
    #1;
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL areset_req_now: got %b want 0", bus.mem_req); end
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL areset_ready_now: got %b want 0", ready); end
    tests++; if (rdata !== 16'h0000) begin fails++; $display("FAIL areset_rdata: got %h want 0000", rdata); end
    tick();
    reset     = 1'b1;
    cpu_state = `CPU_FETCH_BEGIN;
    tick();
    tests++; if (bus.mem_req !== 1'b0 || ready !== 1'b0) begin fails++; $display("FAIL areset_post_idle: got req=%b ready=%b want 0 0", bus.mem_req, ready); end
    cpu_state     = `CPU_FETCH_IO;
    pc_addr       = 16'h0044;
    bus.mem_rdata = 16'h0F0F;
    tick();
    tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0044) begin fails++; $display("FAIL areset_reissue: got req=%b addr=%h want 1 0044", bus.mem_req, bus.mem_addr); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tests++; if (ready !== 1'b1 || rdata !== 16'h0F0F) begin fails++; $display("FAIL areset_complete: got ready=%b rdata=%h want 1 0f0f", ready, rdata); end
    tick();
    cpu_state = `CPU_FETCH_END;
    tick();
    tick();
  endtask

`ifdef CPU_IO_TIMEOUT_EN
  task automatic test_timeout();
    cpu_state     = `CPU_EXEC_LOAD_IO;
    data_addr     = 16'h0500;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h5A5A;
    for (int c = 1; c <= 4; c++) begin
      tick();
      tests++; if (bus.mem_req !== 1'b1 || ready !== 1'b0) begin fails++; $display("FAIL tmo_busy_c%0d: got req=%b ready=%b want 1 0", c, bus.mem_req, ready); end
    end
    tick();
    tests++; if (ready !== 1'b1 || io_err !== 1'b1) begin fails++; $display("FAIL tmo_expire: got ready=%b err=%b want 1 1", ready, io_err); end
    tests++; if (rdata !== 16'hFFFF) begin fails++; $display("FAIL tmo_rdata: got %h want ffff", rdata); end
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL tmo_req: got %b want 0", bus.mem_req); end
    tick();
    cpu_state = `CPU_EXEC_END;
    tests++; if (ready !== 1'b0 || io_err !== 1'b0) begin fails++; $display("FAIL tmo_clear: got ready=%b err=%b want 0 0", ready, io_err); end
    tick();
    tick();
    cpu_state = `CPU_EXEC_LOAD_IO;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) bus.mem_ack = 1'b1;
    end
    tick();
    bus.mem_ack = 1'b0;
    tests++; if (ready !== 1'b1 || io_err !== 1'b0) begin fails++; $display("FAIL tmo_ack_wins: got ready=%b err=%b want 1 0", ready, io_err); end
    tests++; if (rdata !== 16'h5A5A) begin fails++; $display("FAIL tmo_ack_rdata: got %h want 5a5a", rdata); end
    tick();
    cpu_state = `CPU_EXEC_END;
    tick();
    tick();
  endtask
`endif

  initial begin
    tests         = 0;
    fails         = 0;
    reset         = 1'b0;
    cpu_state     = `CPU_FETCH_BEGIN;
    pc_addr       = 16'h0000;
    data_addr     = 16'h0000;
    wdata         = 16'h0000;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;
    test_reset();
    test_fetch();
    test_store();
    test_back_to_back();
    test_abort();
    test_async_reset();
`ifdef CPU_IO_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
